// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter; host pushes words into a FIFO and each
// word is sent as BYTES_PER_WORD 8N1/8N2 frames, LS byte first, each byte LSB first.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   div_en, div_in    strobe latching clocks-per-bit into the divider (0 = disabled)
//   wr_en, wr_data    push a word into the FIFO
//   full, level       FIFO full flag and word count
//   wr_err            1-cycle pulse: push attempted while full, word dropped
//   ser_tx            registered serial line, idle high
//   tx_busy, tx_empty shifter mid-word; FIFO empty and shifter idle
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits (even, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                div_en,
  input  logic [15:0]                         div_in,
  input  logic                                wr_en,
  input  logic [8*BYTES_PER_WORD-1:0]         wr_data,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,
  output logic                                wr_err,
  output logic                                ser_tx,
  output logic                                tx_busy,
  output logic                                tx_empty
);
  localparam int W = 8 * BYTES_PER_WORD;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [15:0] div_reg, div_sh, div_sh_n, cnt, cnt_n;
  logic [W-1:0] word, word_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n;
  state_t state, state_n;
  logic push, pop, bit_end, par, ser_n;
  assign full = level == LW'(FIFO_DEPTH);
  assign push = wr_en && !full;
  assign tx_busy = state != IDLE;
  assign tx_empty = level == '0 && state == IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_idx;
    byte_n = byte_idx;
    word_n = word;
    div_sh_n = div_sh;
    pop = 1'b0;
    bit_end = cnt == div_sh - 16'd1;
    if (state == IDLE) begin
      if (level != '0 && div_reg != '0) begin
        pop = 1'b1;
        state_n = START;
        cnt_n = '0;
        bit_n = '0;
        byte_n = '0;
        word_n = mem[rp];
        div_sh_n = div_reg;
      end
    end else if (bit_end) begin
      cnt_n = '0;
      case (state)
        START: begin
          state_n = DATA;
          bit_n = '0;
        end
        DATA: begin
          state_n = bit_idx == 3'd7 ? AFTER_DATA : DATA;
          bit_n = bit_idx == 3'd7 ? 3'd0 : bit_idx + 3'd1;
        end
        PARITY: begin
          state_n = STOP;
          bit_n = '0;
        end
        STOP: begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            // more bytes in this word follow immediately, without an idle gap
            if (byte_idx == 2'(BYTES_PER_WORD - 1)) state_n = IDLE;
            else begin
              state_n = START;
              byte_n = byte_idx + 2'd1;
              word_n = word >> 8;
            end
          end else bit_n = bit_idx + 3'd1;
        end
        default: state_n = IDLE;
      endcase
    end else cnt_n = cnt + 16'd1;
    par = ^word_n[7:0] ^ 1'(PARITY_ODD);
    // ser_tx is registered from the next state so the line changes on the transition edge
    ser_n = state_n == START ? 1'b0 :
            state_n == DATA ? word_n[bit_n] :
            state_n == PARITY ? par : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_reg <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      wr_err <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      div_sh <= '0;
      ser_tx <= 1'b1;
    end else begin
      if (div_en) div_reg <= div_in;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      wr_err <= wr_en && full;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      word <= word_n;
      div_sh <= div_sh_n;
      ser_tx <= ser_n;
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (default parameters).
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FB = 10 + P;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div_en = 1'b0;
  logic [15:0] div_in = '0;
  logic wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic full, wr_err, ser_tx, tx_busy, tx_empty;
  logic [3:0] level;
  int passed = 0;
  int total = 0;
  logic [31:0] words [10];
  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .div_en(div_en), .div_in(div_in), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .level(level), .wr_err(wr_err),
    .ser_tx(ser_tx), .tx_busy(tx_busy), .tx_empty(tx_empty)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Starts on the pop edge; samples each bit mid-way and checks every start bit lands on time.
  task automatic capture(input logic [31:0] w, input int div, input string nm);
    logic [7:0] by;
    logic [FB-1:0] exp, got;
    for (int b = 0; b < 4; b++) begin
      by = w[8*b +: 8];
      exp = '1;
      exp[0] = 1'b0;
      exp[8:1] = by;
      if (P == 1) exp[9] = ^by;
      got = '0;
      total++;
      if (ser_tx !== 1'b0) $display("FAIL %s start%0d: ser_tx=%b exp 0", nm, b, ser_tx);
      else passed++;
      for (int i = 0; i < FB; i++)
        for (int c = 0; c < div; c++) begin
          if (c == div / 2) got[i] = ser_tx;
          tick(1);
        end
      total++;
      if (got !== exp) $display("FAIL %s frame%0d: got %b exp %b", nm, b, got, exp);
      else passed++;
    end
  endtask
  task automatic test_reset;
    tick(2);
    total += 6;
    if (ser_tx !== 1'b1) $display("FAIL rst ser_tx: got %b exp 1", ser_tx); else passed++;
    if (full !== 1'b0) $display("FAIL rst full: got %b exp 0", full); else passed++;
    if (level !== 4'd0) $display("FAIL rst level: got %0d exp 0", level); else passed++;
    if (wr_err !== 1'b0) $display("FAIL rst wr_err: got %b exp 0", wr_err); else passed++;
    if (tx_busy !== 1'b0) $display("FAIL rst tx_busy: got %b exp 0", tx_busy); else passed++;
    if (tx_empty !== 1'b1) $display("FAIL rst tx_empty: got %b exp 1", tx_empty); else passed++;
    rst = 1'b0;
    tick(1);
  endtask
  task automatic test_div_unset(input string nm);
    int lows = 0;
    wr_en = 1'b1;
    wr_data = 32'h8102_0408;
    tick(1);
    wr_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ser_tx !== 1'b1) lows++;
      tick(1);
    end
    total += 3;
    if (lows !== 0) $display("FAIL %s ser_low: got %0d exp 0", nm, lows); else passed++;
    if (level !== 4'd1) $display("FAIL %s level: got %0d exp 1", nm, level); else passed++;
    if (tx_empty !== 1'b0) $display("FAIL %s tx_empty: got %b exp 0", nm, tx_empty); else passed++;
  endtask
  task automatic test_frame;
    div_en = 1'b1;
    div_in = 16'd2;
    tick(1);
    div_en = 1'b0;
    total++;
    if (tx_busy !== 1'b0) $display("FAIL frm early_pop: got %b exp 0", tx_busy); else passed++;
    tick(1);
    total += 2;
    if (level !== 4'd0) $display("FAIL frm pop_level: got %0d exp 0", level); else passed++;
    if (tx_busy !== 1'b1) $display("FAIL frm busy: got %b exp 1", tx_busy); else passed++;
    capture(32'h8102_0408, 2, "frm");
    total += 2;
    if (tx_empty !== 1'b1) $display("FAIL frm tx_empty: got %b exp 1", tx_empty); else passed++;
    if (ser_tx !== 1'b1) $display("FAIL frm idle_line: got %b exp 1", ser_tx); else passed++;
  endtask
  task automatic test_div_change;
    wr_en = 1'b1;
    wr_data = 32'h1122_3344;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    fork
      capture(32'h1122_3344, 2, "dv1");
      begin
        tick(10);
        div_en = 1'b1;
        div_in = 16'd4;
        tick(1);
        div_en = 1'b0;
        wr_en = 1'b1;
        wr_data = 32'h55AA_0FF0;
        tick(1);
        wr_en = 1'b0;
      end
    join
    total += 2;
    if (tx_busy !== 1'b0) $display("FAIL dv1 end_busy: got %b exp 0", tx_busy); else passed++;
    if (level !== 4'd1) $display("FAIL dv1 level: got %0d exp 1", level); else passed++;
    tick(1);
    capture(32'h55AA_0FF0, 4, "dv2");
    total++;
    if (tx_empty !== 1'b1) $display("FAIL dv2 tx_empty: got %b exp 1", tx_empty); else passed++;
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) words[i] = (32'(i) * 32'h1357_9BDF) ^ 32'hA5C3_0F96;
    div_en = 1'b1;
    div_in = 16'd16;
    tick(1);
    div_en = 1'b0;
    wr_en = 1'b1;
    wr_data = words[0];
    tick(1);
    wr_data = words[1];
    tick(1);
    fork
      capture(words[0], 16, "b2b0");
      begin
        for (int i = 2; i < 10; i++) begin
          wr_data = words[i];
          tick(1);
          if (i == 8) begin
            total += 2;
            if (full !== 1'b1) $display("FAIL b2b full: got %b exp 1", full); else passed++;
            if (level !== 4'd8) $display("FAIL b2b level8: got %0d exp 8", level); else passed++;
          end
          if (i == 9) begin
            total += 2;
            if (wr_err !== 1'b1) $display("FAIL b2b wr_err: got %b exp 1", wr_err); else passed++;
            if (level !== 4'd8) $display("FAIL b2b drop_level: got %0d exp 8", level); else passed++;
          end
        end
        wr_en = 1'b0;
        tick(1);
        total++;
        if (wr_err !== 1'b0) $display("FAIL b2b wr_err_pulse: got %b exp 0", wr_err); else passed++;
      end
    join
    total++;
    if (tx_busy !== 1'b0) $display("FAIL b2b gap_busy: got %b exp 0", tx_busy); else passed++;
    for (int k = 1; k < 9; k++) begin
      tick(1);
      capture(words[k], 16, $sformatf("b2b%0d", k));
    end
    total += 2;
    if (tx_empty !== 1'b1) $display("FAIL b2b drained: got %b exp 1", tx_empty); else passed++;
    if (level !== 4'd0) $display("FAIL b2b end_level: got %0d exp 0", level); else passed++;
  endtask
  task automatic test_reset_mid;
    wr_en = 1'b1;
    wr_data = 32'h8102_0408;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    tick(1);
    wr_en = 1'b0;
    tick(2 * FB * 16 + 20 - 1);
    total++;
    if (ser_tx !== 1'b0) $display("FAIL rmid pre_ser: got %b exp 0", ser_tx); else passed++;
    rst = 1'b1;
    #1;
    total += 4;
    if (ser_tx !== 1'b1) $display("FAIL rmid ser_tx: got %b exp 1", ser_tx); else passed++;
    if (level !== 4'd0) $display("FAIL rmid level: got %0d exp 0", level); else passed++;
    if (tx_busy !== 1'b0) $display("FAIL rmid tx_busy: got %b exp 0", tx_busy); else passed++;
    if (tx_empty !== 1'b1) $display("FAIL rmid tx_empty: got %b exp 1", tx_empty); else passed++;
    #1;
    rst = 1'b0;
    tick(1);
    test_div_unset("rpost");
  endtask
  initial begin
    test_reset;
    test_div_unset("unset");
    test_frame;
    test_div_change;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
